// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file addressing.
package cpu_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/cpu_rr_arbiter.sv
// Combinational round-robin arbiter: scans req starting at ptr, returns a one-hot grant.
module cpu_rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/cpu_regfile_wb_ctrl.sv
// Writeback arbiter + registered write stage for cpu_regfile, with a pending-write
// scoreboard used by decode for RAW checks and WAW issue stalls.
module cpu_regfile_wb_ctrl
    import cpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic [4:0]                issue_rd,
    output logic                      issue_ready,
    input  logic [4:0]                rs1_addr,
    input  logic [4:0]                rs2_addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    input  logic [NUM_REQ-1:0]        wb_valid,
    output logic [NUM_REQ-1:0]        wb_ready,
    input  logic [NUM_REQ*5-1:0]      wb_rd,
    input  logic [NUM_REQ*XLEN-1:0]   wb_data,
    input  logic                      flush,
    output logic [4:0]                rd_addr,
    output logic [XLEN-1:0]           rd_data,
    output logic                      rd_write_en
);
    localparam int IW = $clog2(NUM_REQ);

    reg_addr_t [NUM_REQ-1:0]        req_rd;
    logic [NUM_REQ-1:0][XLEN-1:0]   req_data;
    logic [NUM_REGS-1:0]            busy, busy_nxt;
    logic [IW-1:0]                  rr_ptr, gnt_idx;
    logic [NUM_REQ-1:0]             gnt;
    logic                           xfer, issue_fire;
    reg_addr_t                      sel_rd;
    logic [XLEN-1:0]                sel_data;

    assign req_rd   = wb_rd;
    assign req_data = wb_data;

    cpu_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req     (wb_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grants keep flowing during flush so requesters drain; the data is just dropped.
    assign wb_ready   = reset ? gnt : '0;
    assign xfer       = |wb_ready;
    assign sel_rd     = req_rd[gnt_idx];
    assign sel_data   = req_data[gnt_idx];

    assign issue_ready = reset & ~busy[issue_rd] & ~flush;
    assign issue_fire  = issue_valid & issue_ready;
    assign rs1_busy    = busy[rs1_addr];
    assign rs2_busy    = busy[rs2_addr];

    // Set is applied after clear so a same-register collision leaves it pending.
    always_comb begin
        busy_nxt = busy;
        if (rd_write_en) busy_nxt[rd_addr] = 1'b0;
        if (issue_fire)  busy_nxt[issue_rd] = 1'b1;
        if (flush)       busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy        <= '0;
            rr_ptr      <= '0;
            rd_write_en <= 1'b0;
            rd_addr     <= '0;
            rd_data     <= '0;
        end else begin
            busy <= busy_nxt;
            if (xfer)
                rr_ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
            if (xfer && !flush && sel_rd != '0) begin
                rd_write_en <= 1'b1;
                rd_addr     <= sel_rd;
                rd_data     <= sel_data;
            end else begin
                rd_write_en <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cpu_regfile_wb_ctrl.sv
// Bench for cpu_regfile_wb_ctrl: directed scenarios then random traffic vs a behavioural model.
module tb_cpu_regfile_wb_ctrl;
    localparam int XLEN    = 32;
    localparam int NUM_REQ = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    issue_valid, issue_ready;
    logic [4:0]              issue_rd, rs1_addr, rs2_addr;
    logic                    rs1_busy, rs2_busy;
    logic [NUM_REQ-1:0]      wb_valid, wb_ready;
    logic [NUM_REQ*5-1:0]    wb_rd;
    logic [NUM_REQ*XLEN-1:0] wb_data;
    logic                    flush;
    logic [4:0]              rd_addr;
    logic [XLEN-1:0]         rd_data;
    logic                    rd_write_en;

    cpu_regfile_wb_ctrl #(.XLEN(XLEN), .NUM_REQ(NUM_REQ)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .rd_addr(rd_addr), .rd_data(rd_data), .rd_write_en(rd_write_en)
    );

    always #5 clk = ~clk;

    // Stand-in for cpu_regfile, written from the DUT's write port.
    logic [XLEN-1:0] rf [32];
    initial for (int r = 0; r < 32; r++) rf[r] = '0;
    always @(posedge clk) if (rd_write_en && rd_addr != 0) rf[rd_addr] <= rd_data;

    int vectors = 0, errs = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester state: each holds its request until granted.
    logic            rv   [NUM_REQ];
    logic [4:0]      rrd  [NUM_REQ];
    logic [XLEN-1:0] rdat [NUM_REQ];
    int              req_mode;   // 0: drop after grant, 1: keep presenting, 2: random refill

    // Behavioural model
    bit              mbusy [32];
    int              mptr;
    bit              mwe;
    logic [4:0]      maddr;
    logic [XLEN-1:0] mdata;
    logic [XLEN-1:0] mrf [32];

    task automatic model_reset();
        for (int r = 0; r < 32; r++) mbusy[r] = 0;
        mptr = 0; mwe = 0; maddr = '0; mdata = '0;
    endtask

    task automatic drive_req();
        for (int i = 0; i < NUM_REQ; i++) begin
            wb_valid[i]            = rv[i];
            wb_rd[5*i +: 5]        = rrd[i];
            wb_data[XLEN*i +: XLEN] = rdat[i];
        end
    endtask

    // Apply current inputs, check every output against the model, advance one clock.
    task automatic cycle();
        int g;
        bit fire;
        logic [NUM_REQ-1:0] eg;
        drive_req();
        #1;
        g = -1;
        if (reset)
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (mptr + k) % NUM_REQ;
                if (g < 0 && rv[i]) g = i;
            end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        fire = reset && issue_valid && !mbusy[issue_rd] && !flush;
        chk("wb_ready", wb_ready, eg);
        chk("issue_ready", issue_ready, reset && !mbusy[issue_rd] && !flush);
        chk("rs1_busy", rs1_busy, mbusy[rs1_addr]);
        chk("rs2_busy", rs2_busy, mbusy[rs2_addr]);
        chk("rd_write_en", rd_write_en, mwe);
        if (mwe) begin
            chk("rd_addr", rd_addr, maddr);
            chk("rd_data", rd_data, mdata);
        end
        @(posedge clk);
        if (reset) begin
            if (mwe && maddr != 0) mrf[maddr] = mdata;
            if (flush) begin
                for (int r = 0; r < 32; r++) mbusy[r] = 0;
                mwe = 0;
            end else begin
                if (mwe) mbusy[maddr] = 0;
                if (fire && issue_rd != 0) mbusy[issue_rd] = 1;
                mwe = (g >= 0) && (rrd[g] != 0);
                if (mwe) begin maddr = rrd[g]; mdata = rdat[g]; end
            end
            if (g >= 0) begin
                mptr = (g + 1) % NUM_REQ;
                if (req_mode != 1) rv[g] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        issue_valid = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0; flush = 0;
        for (int i = 0; i < NUM_REQ; i++) begin rv[i] = 0; rrd[i] = 0; rdat[i] = 0; end
    endtask

    logic [NUM_REQ-1:0] exp_seq [4];

    initial begin
        for (int r = 0; r < 32; r++) mrf[r] = '0;
        model_reset();
        req_mode = 0;
        clear_inputs();
        reset = 0;
        rv[1] = 1; rrd[1] = 3; rdat[1] = 32'h1111; issue_valid = 1; issue_rd = 3;
        drive_req();
        @(negedge clk);
        cycle(); cycle();
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        clear_inputs();
        reset = 1;

        // issue x1, then a second issue must stall
        issue_valid = 1; issue_rd = 1; rs1_addr = 1;
        #1 chk("iss_x1_ready", issue_ready, 1);
        cycle();
        #1 chk("rs1_busy_x1", rs1_busy, 1);
        chk("iss_x1_again", issue_ready, 0);
        cycle();
        issue_valid = 0;

        // single writeback from req0
        rv[0] = 1; rrd[0] = 1; rdat[0] = 32'h12345678;
        drive_req();
        #1 chk("wb1_ready", wb_ready, 3'b001);
        cycle();
        #1 chk("wb1_we", rd_write_en, 1);
        chk("wb1_addr", rd_addr, 1);
        chk("wb1_data", rd_data, 32'h12345678);
        chk("wb1_still_busy", rs1_busy, 1);
        cycle();
        #1 chk("wb1_busy_clr", rs1_busy, 0);
        chk("rf_x1", rf[1], 32'h12345678);
        cycle();

        // write to x0 from req2 together with an issue to x0
        rv[2] = 1; rrd[2] = 0; rdat[2] = 32'hDEADBEEF;
        issue_valid = 1; issue_rd = 0; rs1_addr = 0;
        drive_req();
        #1 chk("x0_ready", wb_ready, 3'b100);
        chk("x0_issue_ready", issue_ready, 1);
        cycle();
        issue_valid = 0;
        #1 chk("x0_no_we", rd_write_en, 0);
        chk("x0_not_busy", rs1_busy, 0);
        cycle();
        chk("rf_x0", rf[0], 0);

        // three requesters streaming back-to-back
        req_mode = 1;
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
        rv[0] = 1; rrd[0] = 5; rdat[0] = 32'h55555555;
        rv[1] = 1; rrd[1] = 6; rdat[1] = 32'hAAAAAAAA;
        rv[2] = 1; rrd[2] = 7; rdat[2] = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            drive_req();
            #1 chk("rr_order", wb_ready, exp_seq[i]);
            if (i > 0) chk("stream_we", rd_write_en, 1);
            cycle();
        end
        req_mode = 0;
        for (int i = 0; i < NUM_REQ; i++) rv[i] = 0;
        #1 chk("stream_last_we", rd_write_en, 1);
        chk("stream_last_addr", rd_addr, 5);
        cycle();
        chk("rf_x6", rf[6], 32'hAAAAAAAA);
        chk("rf_x7", rf[7], 32'hFFFFFFFF);

        // flush collides with a writeback grant to x2
        issue_valid = 1; issue_rd = 2; cycle();
        issue_rd = 3; cycle();
        issue_valid = 0;
        rv[1] = 1; rrd[1] = 2; rdat[1] = 32'hCAFEF00D; flush = 1;
        rs1_addr = 2; rs2_addr = 3;
        drive_req();
        #1 chk("flush_grant", wb_ready, 3'b010);
        cycle();
        flush = 0;
        #1 chk("flush_we", rd_write_en, 0);
        chk("flush_rs1", rs1_busy, 0);
        chk("flush_rs2", rs2_busy, 0);
        cycle();
        chk("rf_x2", rf[2], 0);

        // async reset while a write is in flight
        issue_valid = 1; issue_rd = 4; rs1_addr = 4;
        rv[0] = 1; rrd[0] = 9; rdat[0] = 32'h900DCAFE;
        cycle();
        issue_valid = 0;
        rv[1] = 1; rrd[1] = 10; rdat[1] = 32'h0A0A0A0A;
        drive_req();
        #1 chk("pre_rst_we", rd_write_en, 1);
        #2 reset = 0;
        #1 chk("async_we", rd_write_en, 0);
        chk("async_busy", rs1_busy, 0);
        chk("async_ready", wb_ready, 0);
        model_reset();
        @(negedge clk);
        cycle();
        reset = 1;
        rv[0] = 1; rv[2] = 1; rrd[2] = 11; rdat[2] = 32'hB0B0B0B0;
        drive_req();
        #1 chk("post_rst_grant", wb_ready, 3'b001);
        cycle();

        // random traffic
        req_mode = 2;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!rv[i] && $urandom_range(1, 0) == 1) begin
                    rv[i]   = 1;
                    rrd[i]  = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
                    rdat[i] = $urandom;
                end
            issue_valid = $urandom_range(1, 0) == 1;
            issue_rd    = 5'($urandom_range(31, 0));
            rs1_addr    = 5'($urandom_range(31, 0));
            rs2_addr    = 5'($urandom_range(31, 0));
            flush       = $urandom_range(15, 0) == 0;
            cycle();
        end
        clear_inputs();
        cycle(); cycle();
        for (int r = 0; r < 32; r++) chk("rf_final", rf[r], mrf[r]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
